// File: rtl/display_2dig_mux_if.sv
// Digit inputs from the BCD counter, display options, and the multiplexed
// 7-segment outputs that drive the two-digit display.
interface display_2dig_mux_if;
   logic [3:0] units;
   logic [3:0] tens;
   logic       blank_zero;
   logic       blink_en;
   logic [6:0] seg;
   logic [1:0] dig;

   modport master (
      output units, tens, blank_zero, blink_en,
      input  seg, dig
   );

   modport slave (
      input  units, tens, blank_zero, blink_en,
      output seg, dig
   );
endinterface

// File: rtl/display_2dig_mux.sv
// Two-digit multiplexed 7-segment driver: time-sliced units/tens slots with
// guard gaps, optional leading-zero blanking, and whole-display blinking.
module display_2dig_mux #(
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 4,
   parameter int BLINK_FRAMES = 25,
   parameter int ACTIVE_LOW   = 1
) (
   input logic               clock,
   input logic               reset,
   display_2dig_mux_if.slave bus
);

   localparam logic [1:0] GUARD_U = 2'd0;
   localparam logic [1:0] SHOW_U  = 2'd1;
   localparam logic [1:0] GUARD_T = 2'd2;
   localparam logic [1:0] SHOW_T  = 2'd3;

   localparam int CNT_W = $clog2((SCAN_DIV > GUARD) ? SCAN_DIV : GUARD);
   localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
   localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLINK_FRAMES - 1);

   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0] DIG_OFF = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
   localparam logic [1:0] DIG_U   = (ACTIVE_LOW != 0) ? 2'b10 : 2'b01;
   localparam logic [1:0] DIG_T   = (ACTIVE_LOW != 0) ? 2'b01 : 2'b10;

   // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] pat;
      case (bcd)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h40;
      endcase
      return pat;
   endfunction

   function automatic logic [6:0] seg_drive(input logic [6:0] pat);
      return (ACTIVE_LOW != 0) ? ~pat : pat;
   endfunction

   logic [1:0]       state;
   logic [CNT_W-1:0] slot_cnt;
   logic [FC_W-1:0]  frame_cnt;
   logic             blink_phase;
   logic [6:0]       seg_r;
   logic [1:0]       dig_r;

   logic slot_done;
   logic dark;
   logic tens_blank;

   always_comb begin
      slot_done  = 1'b0;
      if ((state == GUARD_U) || (state == GUARD_T))
         slot_done = (slot_cnt == GUARD_LAST);
      else
         slot_done = (slot_cnt == SCAN_LAST);
      dark       = bus.blink_en && blink_phase;
      tens_blank = bus.blank_zero && (bus.tens == 4'd0);
   end

   // Slot sequencing; seg/dig are loaded on the same edge the state moves.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= GUARD_U;
         slot_cnt <= '0;
         seg_r    <= SEG_OFF;
         dig_r    <= DIG_OFF;
      end else if (slot_done) begin
         slot_cnt <= '0;
         case (state)
            GUARD_U: begin
               state <= SHOW_U;
               seg_r <= dark ? SEG_OFF : seg_drive(seg_decode(bus.units));
               dig_r <= dark ? DIG_OFF : DIG_U;
            end
            SHOW_U: begin
               state <= GUARD_T;
               seg_r <= SEG_OFF;
               dig_r <= DIG_OFF;
            end
            GUARD_T: begin
               state <= SHOW_T;
               seg_r <= (dark || tens_blank) ? SEG_OFF : seg_drive(seg_decode(bus.tens));
               dig_r <= (dark || tens_blank) ? DIG_OFF : DIG_T;
            end
            default: begin
               state <= GUARD_U;
               seg_r <= SEG_OFF;
               dig_r <= DIG_OFF;
            end
         endcase
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // Frame counter advances at the end of each tens slot while blinking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!bus.blink_en) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (slot_done && (state == SHOW_T)) begin
         if (frame_cnt == FC_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   assign bus.seg = seg_r;
   assign bus.dig = dig_r;

endmodule

// File: tb/tb_display_2dig_mux.sv
// Randomized bench for display_2dig_mux with a frame-position reference model
// and literal pins for the documented display scenarios.
module tb_display_2dig_mux;

   localparam int SCAN_DIV = 4;
   localparam int GUARD    = 1;
   localparam int BF       = 2;
   localparam int FRAME    = 2 * (GUARD + SCAN_DIV);
   localparam int U_START  = GUARD;
   localparam int T_GUARD  = GUARD + SCAN_DIV;
   localparam int T_START  = 2 * GUARD + SCAN_DIV;

   localparam logic [6:0] DEC_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic chk_en = 1'b0;

   int checks   = 0;
   int failures = 0;

   display_2dig_mux_if bus();

   display_2dig_mux #(
      .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // Reference: position within the frame plus frames elapsed while blinking.
   int         m_pos;
   int         m_k;
   logic [6:0] m_seg;
   logic [1:0] m_dig;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pos <= 0;
         m_k   <= 0;
         m_seg <= 7'h7F;
         m_dig <= 2'b11;
      end else begin
         m_pos <= (m_pos + 1) % FRAME;
         if (!bus.blink_en) m_k <= 0;
         else if (m_pos == FRAME - 1) m_k <= m_k + 1;
         if ((m_pos + 1) % FRAME == U_START) begin
            if (bus.blink_en && ((m_k / BF) % 2 == 1)) begin
               m_seg <= 7'h7F; m_dig <= 2'b11;
            end else begin
               m_seg <= ~DEC_HI[bus.units]; m_dig <= 2'b10;
            end
         end else if ((m_pos + 1) % FRAME == T_START) begin
            if ((bus.blink_en && ((m_k / BF) % 2 == 1)) || (bus.blank_zero && bus.tens == 4'd0)) begin
               m_seg <= 7'h7F; m_dig <= 2'b11;
            end else begin
               m_seg <= ~DEC_HI[bus.tens]; m_dig <= 2'b01;
            end
         end else if ((m_pos + 1) % FRAME == 0 || (m_pos + 1) % FRAME == T_GUARD) begin
            m_seg <= 7'h7F; m_dig <= 2'b11;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         checks++;
         if (bus.seg !== m_seg || bus.dig !== m_dig) begin
            failures++;
            $display("FAIL model_cmp t=%0t pos=%0d: seg=%h dig=%b expected seg=%h dig=%b",
                     $time, m_pos, bus.seg, bus.dig, m_seg, m_dig);
         end
         checks++;
         if ($countones(~bus.dig) > 1) begin
            failures++;
            $display("FAIL one_digit t=%0t: dig=%b expected at most one active", $time, bus.dig);
         end
      end
   end

   task automatic lit_check(input string name, input logic [6:0] es, input logic [1:0] ed);
      checks++;
      if (bus.seg !== es || bus.dig !== ed) begin
         failures++;
         $display("FAIL %s: seg=%h dig=%b expected seg=%h dig=%b", name, bus.seg, bus.dig, es, ed);
      end
   endtask

   task automatic goto_pos(input int p);
      @(negedge clock);
      for (int i = 0; i < 2 * FRAME && m_pos != p; i++) @(negedge clock);
      checks++;
      if (m_pos != p) begin
         failures++;
         $display("FAIL goto_pos: pos=%0d expected %0d", m_pos, p);
      end
   endtask

   task automatic reset_pulse_after_negedge();
      #1 reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
   endtask

   initial begin
      bus.units = 4'd0; bus.tens = 4'd0; bus.blank_zero = 1'b0; bus.blink_en = 1'b0;
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      lit_check("reset_state", 7'h7F, 2'b11);
      @(negedge clock);
      bus.units = 4'd7; bus.tens = 4'd4;
      @(posedge clock);
      #1 reset = 1'b1;

      // Basic digits 7 / 4
      goto_pos(1); lit_check("show_u_7", 7'h78, 2'b10);
      goto_pos(5); lit_check("guard_t", 7'h7F, 2'b11);
      goto_pos(6); lit_check("show_t_4", 7'h19, 2'b01);
      bus.units = 4'd5; bus.tens = 4'd0; bus.blank_zero = 1'b1;
      goto_pos(0); lit_check("guard_u", 7'h7F, 2'b11);

      // Leading-zero blanking
      goto_pos(1); lit_check("show_u_5", 7'h12, 2'b10);
      goto_pos(6); lit_check("tens_blanked", 7'h7F, 2'b11);
      bus.blank_zero = 1'b0;
      goto_pos(6); lit_check("tens_zero_shown", 7'h40, 2'b01);

      // Invalid codes become a dash
      bus.units = 4'hC; bus.tens = 4'hF;
      goto_pos(1); lit_check("units_dash", 7'h3F, 2'b10);
      goto_pos(6); lit_check("tens_dash", 7'h3F, 2'b01);

      // Mid-slot input change is ignored
      bus.units = 4'd3;
      goto_pos(1); lit_check("units_3", 7'h30, 2'b10);
      goto_pos(2); bus.units = 4'd8;
      goto_pos(4); lit_check("units_held", 7'h30, 2'b10);
      goto_pos(1); lit_check("units_8_next", 7'h00, 2'b10);

      // Asynchronous reset during the tens slot
      goto_pos(7);
      #2 reset = 1'b0;
      #1 lit_check("async_reset", 7'h7F, 2'b11);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock); lit_check("post_reset_guard", 7'h7F, 2'b11);
      for (int i = 0; i < SCAN_DIV; i++) begin
         @(negedge clock); lit_check("post_reset_show_u", 7'h00, 2'b10);
      end
      @(negedge clock); lit_check("post_reset_guard_t", 7'h7F, 2'b11);

      // Blinking from reset: two lit frames, two dark frames
      @(negedge clock);
      bus.blink_en = 1'b1; bus.units = 4'd9; bus.tens = 4'd2;
      reset_pulse_after_negedge();
      for (int f = 0; f <= 6; f++) begin
         goto_pos(1);
         if ((f / 2) % 2 == 1) lit_check("blink_u_dark", 7'h7F, 2'b11);
         else lit_check("blink_u_lit", 7'h10, 2'b10);
         if (f < 6) begin
            goto_pos(6);
            if ((f / 2) % 2 == 1) lit_check("blink_t_dark", 7'h7F, 2'b11);
            else lit_check("blink_t_lit", 7'h24, 2'b01);
         end
      end
      goto_pos(3); bus.blink_en = 1'b0;
      goto_pos(6); lit_check("blink_cleared", 7'h24, 2'b01);

      // Randomized traffic checked by the model
      bus.blink_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         bus.units      = 4'($urandom_range(0, 15));
         bus.tens       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         bus.blank_zero = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) bus.blink_en = ~bus.blink_en;
         if ($urandom_range(0, 149) == 0) begin
            #1 reset = 1'b0;
            @(negedge clock);
            #1 reset = 1'b1;
         end
      end
      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
